// File: rtl/tick_rate_pkg.sv
// tick_rate_pkg: shared types and rate table for the tick rate controller.
//   state_e     - controller sequencing states (IDLE, RUN, STEP)
//   rate_sel_t  - 2-bit index into RATE_HZ
//   RATE_HZ     - selectable tick rates in Hz
//   rate_div()  - clock cycles per tick for a rate index, never less than 1
package tick_rate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  typedef logic [1:0] rate_sel_t;

  localparam int unsigned RATE_HZ [4] = '{1, 2, 5, 10};

  function automatic int unsigned rate_div(int unsigned clock_hz, rate_sel_t sel);
    int unsigned q;
    q = clock_hz / RATE_HZ[sel];
    if (q == 0) q = 1;
    return q;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: loadable period counter counting 0..div-1.
//   i_clock_50mhz - system clock
//   i_reset       - synchronous active-low reset
//   enable        - advance the count this cycle
//   clear         - force the count back to 0 (wins over enable)
//   div           - period length in cycles (>= 1)
//   wrap          - high in the cycle whose edge completes a period
module tick_prescaler #(
  parameter int unsigned DivWidth = 32
) (
  input  logic                i_clock_50mhz,
  input  logic                i_reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [DivWidth-1:0] div,
  output logic                wrap
);

  logic [DivWidth-1:0] count;

  assign wrap = enable && !clear && (count == div - DivWidth'(1));

  always_ff @(posedge i_clock_50mhz) begin
    if (!i_reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + DivWidth'(1);
    end
  end

endmodule

// File: rtl/tick_rate_controller.sv
// tick_rate_controller: run/stop/single-step sequencer producing one-cycle
// clock-enable ticks at a rate chosen from RATE_HZ, with a load/ack handshake
// for rate changes that only take effect on period boundaries.
//   i_clock_50mhz - system clock
//   i_reset       - synchronous active-low reset
//   i_run         - level, 1 = free-running ticks
//   i_step        - pulse, request one tick while stopped
//   i_rate_sel    - rate table index to load
//   i_rate_load   - pulse, capture i_rate_sel as the pending rate
//   o_tick        - registered one-cycle enable pulse
//   o_running     - 1 while in RUN
//   o_rate_ack    - one-cycle pulse when a loaded rate takes effect
//   o_rate_cur    - rate index currently in effect
//   o_tick_count  - 16-bit wrapping count of ticks, present only when
//                   TICK_RATE_CONTROLLER_TICK_COUNT_EN is defined
module tick_rate_controller
  import tick_rate_pkg::*;
#(
  parameter int unsigned ClockHz  = 50000000,
  parameter int unsigned DivWidth = 32
) (
  input  logic        i_clock_50mhz,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic        i_step,
  input  logic [1:0]  i_rate_sel,
  input  logic        i_rate_load,
  output logic        o_tick,
  output logic        o_running,
  output logic        o_rate_ack,
  output logic [1:0]  o_rate_cur
`ifdef TICK_RATE_CONTROLLER_TICK_COUNT_EN
  ,
  output logic [15:0] o_tick_count
`endif
);

  // Divisors are elaboration-time constants, so the rate mux is a small table.
  localparam logic [DivWidth-1:0] DIV_TABLE [4] = '{
    DivWidth'(rate_div(ClockHz, 2'd0)),
    DivWidth'(rate_div(ClockHz, 2'd1)),
    DivWidth'(rate_div(ClockHz, 2'd2)),
    DivWidth'(rate_div(ClockHz, 2'd3))
  };

  state_e              state;
  rate_sel_t           rate_pend;
  logic                pend_valid;
  logic [DivWidth-1:0] div;
  logic                count_en;
  logic                wrap;

  assign div      = DIV_TABLE[o_rate_cur];
  assign count_en = (state == RUN) && i_run;

  tick_prescaler #(
    .DivWidth (DivWidth)
  ) u_prescaler (
    .i_clock_50mhz (i_clock_50mhz),
    .i_reset       (i_reset),
    .enable        (count_en),
    .clear         (!count_en),
    .div           (div),
    .wrap          (wrap)
  );

  always_ff @(posedge i_clock_50mhz) begin
    if (!i_reset) begin
      state      <= IDLE;
      o_tick     <= 1'b0;
      o_running  <= 1'b0;
      o_rate_ack <= 1'b0;
      o_rate_cur <= '0;
      rate_pend  <= '0;
      pend_valid <= 1'b0;
    end else begin
      o_tick     <= 1'b0;
      o_rate_ack <= 1'b0;

      if (i_rate_load) begin
        rate_pend  <= i_rate_sel;
        pend_valid <= 1'b1;
      end

      case (state)
        IDLE, STEP: begin
          // A load landing this cycle defers application by one cycle, so
          // back-to-back loads collapse into a single ack with the last value.
          if (pend_valid && !i_rate_load) begin
            o_rate_cur <= rate_pend;
            pend_valid <= 1'b0;
            o_rate_ack <= 1'b1;
          end
          if (state == STEP) begin
            o_tick <= 1'b1;
            state  <= IDLE;
          end else if (i_run) begin
            state     <= RUN;
            o_running <= 1'b1;
          end else if (i_step) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (!i_run) begin
            state     <= IDLE;
            o_running <= 1'b0;
          end else if (wrap) begin
            o_tick <= 1'b1;
            // A load coinciding with the wrap is applied directly; the
            // later nonblocking write overrides the capture above.
            if (i_rate_load) begin
              o_rate_cur <= i_rate_sel;
              pend_valid <= 1'b0;
              o_rate_ack <= 1'b1;
            end else if (pend_valid) begin
              o_rate_cur <= rate_pend;
              pend_valid <= 1'b0;
              o_rate_ack <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          o_running <= 1'b0;
        end
      endcase
    end
  end

`ifdef TICK_RATE_CONTROLLER_TICK_COUNT_EN
  always_ff @(posedge i_clock_50mhz) begin
    if (!i_reset) begin
      o_tick_count <= '0;
    end else if (o_tick) begin
      o_tick_count <= o_tick_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tick_rate_controller.sv
// Testbench for tick_rate_controller (ClockHz = 100: div 100/50/20/10).
module tb_tick_rate_controller;

  localparam int unsigned CLK_HZ = 100;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, run = 1'b0, step = 1'b0, load = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       tick, running, ack;
  logic [1:0] cur;
`ifdef TICK_RATE_CONTROLLER_TICK_COUNT_EN
  logic [15:0] tcount;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tick_rate_controller #(
    .ClockHz  (CLK_HZ),
    .DivWidth (16)
  ) dut (
    .i_clock_50mhz (clk),
    .i_reset       (rst_n),
    .i_run         (run),
    .i_step        (step),
    .i_rate_sel    (sel),
    .i_rate_load   (load),
    .o_tick        (tick),
    .o_running     (running),
    .o_rate_ack    (ack),
    .o_rate_cur    (cur)
`ifdef TICK_RATE_CONTROLLER_TICK_COUNT_EN
    , .o_tick_count (tcount)
`endif
  );

`ifdef TICK_RATE_CONTROLLER_TICK_COUNT_EN
  // Second instance with every divisor clamped to 1: ticks every cycle,
  // so the 16-bit tick counter can be driven through its wrap quickly.
  logic        rst2 = 1'b0, run2 = 1'b0;
  logic        tick2, running2, ack2;
  logic [1:0]  cur2;
  logic [15:0] tcount2;

  tick_rate_controller #(
    .ClockHz  (1),
    .DivWidth (4)
  ) dut2 (
    .i_clock_50mhz (clk),
    .i_reset       (rst2),
    .i_run         (run2),
    .i_step        (1'b0),
    .i_rate_sel    (2'd0),
    .i_rate_load   (1'b0),
    .o_tick        (tick2),
    .o_running     (running2),
    .o_rate_ack    (ack2),
    .o_rate_cur    (cur2),
    .o_tick_count  (tcount2)
  );
`endif

  // ---------------- reference model (elapsed-cycle formulation) ----------
  int unsigned m_cyc = 0, m_start = 0;
  int          m_mode = M_IDLE;
  logic        m_tick = 1'b0, m_run = 1'b0, m_ack = 1'b0, m_pend_v = 1'b0;
  logic [1:0]  m_cur = 2'd0, m_pend = 2'd0;
  logic [15:0] m_cnt = 16'd0;

  function automatic int unsigned div_of(logic [1:0] s);
    int unsigned hz;
    case (s)
      2'd0: hz = 1;
      2'd1: hz = 2;
      2'd2: hz = 5;
      default: hz = 10;
    endcase
    div_of = CLK_HZ / hz;
    if (div_of == 0) div_of = 1;
  endfunction

  always @(posedge clk) begin
    bit took;
    m_cyc++;
    if (!rst_n) begin
      m_mode = M_IDLE; m_tick = 0; m_run = 0; m_ack = 0;
      m_cur = 0; m_pend = 0; m_pend_v = 0; m_cnt = 0;
    end else begin
      if (m_tick) m_cnt = m_cnt + 16'd1;
      m_tick = 0; m_ack = 0; took = 0;
      if (m_mode == M_RUN) begin
        if (!run) m_mode = M_IDLE;
        else if (m_cyc - m_start == div_of(m_cur)) begin
          m_tick = 1; m_start = m_cyc;
          if (load) begin m_cur = sel; m_pend_v = 0; m_ack = 1; took = 1; end
          else if (m_pend_v) begin m_cur = m_pend; m_pend_v = 0; m_ack = 1; end
        end
      end else begin
        if (m_pend_v && !load) begin m_cur = m_pend; m_pend_v = 0; m_ack = 1; end
        if (m_mode == M_STEP) begin m_tick = 1; m_mode = M_IDLE; end
        else if (run) begin m_mode = M_RUN; m_start = m_cyc; end
        else if (step) m_mode = M_STEP;
      end
      if (load && !took) begin m_pend = sel; m_pend_v = 1; end
      m_run = (m_mode == M_RUN);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check("model", 32'({tick, running, ack, cur}), 32'({m_tick, m_run, m_ack, m_cur}));
`ifdef TICK_RATE_CONTROLLER_TICK_COUNT_EN
    check("tick_count", 32'(tcount), 32'(m_cnt));
`endif
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic count_events(input int cycles, output int ticks, output int acks);
    ticks = 0; acks = 0;
    repeat (cycles) begin
      cyc();
      if (tick) ticks++;
      if (ack) acks++;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst_n, run, step, load;
    logic [1:0] sel;
    logic [4:0] exp;  // {tick, running, ack, cur}
  } vec_t;

  vec_t tbl [20];

  initial begin
    int n, t, a;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_00}; // reset
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 5'b0_0_0_00}; // load in IDLE
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_1_10}; // applied next cycle
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_10};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 5'b0_0_0_10}; // step
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b1_0_0_10}; // tick 2 cycles later
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_10};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 5'b0_1_0_10}; // run beats step
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5'b0_1_0_10};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_10}; // stop, no tick
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_10};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 5'b0_0_0_10}; // two loads
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 5'b0_0_0_10};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_1_00}; // one ack, last wins
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_00};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 5'b0_0_0_00}; // load then reset
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_00};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_00}; // pending discarded
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b0_0_0_00};

    for (int i = 0; i < 20; i++) begin
      rst_n = tbl[i].rst_n; run = tbl[i].run; step = tbl[i].step;
      load = tbl[i].load; sel = tbl[i].sel;
      cyc();
      check($sformatf("vec%0d", i), 32'({tick, running, ack, cur}), 32'(tbl[i].exp));
    end
    rst_n = 1; run = 0; step = 0; load = 0;

    // A: free run at sel 0
    run = 1;
    wait_tick(300, n); check("run_first_tick_sel0", n, 101);
    check("running_high", 32'(running), 1);
    wait_tick(300, n); check("run_spacing_sel0", n, 100);

    // B: sel 3, stop mid-period at count 4, restart
    run = 0; cyc();
    load = 1; sel = 3; cyc(); load = 0;
    cyc(); cyc();
    check("cur_sel3", 32'(cur), 3);
    run = 1;
    wait_tick(50, n); check("run_first_tick_sel3", n, 11);
    repeat (4) cyc();
    run = 0; cyc();
    check("stop_running_low", 32'({tick, running}), 0);
    count_events(20, t, a); check("stop_no_ticks", t, 0);
    run = 1;
    wait_tick(50, n); check("restart_first_tick", n, 11);

    // C: single step from IDLE, then step ignored in RUN
    run = 0; cyc();
    step = 1; cyc(); step = 0;
    wait_tick(10, n); check("step_latency", n + 1, 2);
    count_events(30, t, a); check("step_single_tick", t, 0);
    run = 1;
    wait_tick(50, n); check("run_after_step", n, 11);
    cyc(); step = 1; cyc(); step = 0;
    wait_tick(50, n); check("step_in_run_spacing", n + 2, 10);

    // D: RUN at sel 1, load sel 2 at count 10
    run = 0; cyc();
    load = 1; sel = 1; cyc(); load = 0;
    cyc(); cyc();
    run = 1;
    wait_tick(100, n); check("run_first_tick_sel1", n, 51);
    repeat (10) cyc();
    load = 1; sel = 2; cyc(); load = 0;
    wait_tick(100, n); check("old_div_until_wrap", n + 11, 50);
    check("ack_at_wrap", 32'(ack), 1);
    check("cur_after_wrap", 32'(cur), 2);
    wait_tick(100, n); check("new_div_spacing", n, 20);

    // E: two loads in one period, then a load on the wrap cycle
    repeat (3) cyc();
    load = 1; sel = 3; cyc(); load = 0;
    cyc();
    load = 1; sel = 0; cyc(); load = 0;
    wait_tick(100, n); check("two_loads_period", n + 6, 20);
    check("two_loads_ack", 32'(ack), 1);
    check("two_loads_last_wins", 32'(cur), 0);
    cyc(); check("two_loads_single_ack", 32'(ack), 0);
    repeat (98) cyc();
    load = 1; sel = 3; cyc(); load = 0;
    check("load_on_wrap", 32'({tick, ack, cur}), 32'({1'b1, 1'b1, 2'd3}));
    wait_tick(50, n); check("load_on_wrap_spacing", n, 10);

    // F: reset mid-period with a pending load
    repeat (3) cyc();
    load = 1; sel = 1; cyc(); load = 0;
    rst_n = 0; run = 0; cyc();
    check("reset_outputs", 32'({tick, running, ack, cur}), 0);
    rst_n = 1;
    count_events(15, t, a);
    check("reset_no_ack", a, 0);
    check("reset_cur", 32'(cur), 0);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 59) == 0) run = ~run;
      step = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 14) == 0);
      sel  = 2'($urandom_range(0, 3));
      cyc();
    end

`ifdef TICK_RATE_CONTROLLER_TICK_COUNT_EN
    // Tick counter wrap on the every-cycle instance
    rst2 = 0; @(negedge clk);
    rst2 = 1; run2 = 1;
    n = 0;
    while (tcount2 != 16'hFFFF && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("tick_count_reach_ffff", 32'(tcount2), 32'hFFFF);
    @(negedge clk);
    check("tick_count_wrap", 32'(tcount2), 0);
    @(negedge clk);
    rst2 = 0; @(negedge clk);
    check("tick_count_reset", 32'(tcount2), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
